// File: rtl/reg_wb_arbiter.sv
`timescale 1ns/1ps
// Purpose  : arbitrates two register-file writeback requesters (ALU, load) into one write port.
// Latency  : 2 cycles accept-to-wr_en when uncontended; +1 cycle per older or tie-winning write ahead.
// Backpress: per-requester ready is low only while its holding slot is full and not granted this cycle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/addr/data, reqN_ready valid-ready offer from requester N (N = 0 ALU, 1 load)
//   wr_en/wr_addr/wr_data           registered register-file write port (addr 0 never writes)
//   busy_mask                       bit i set while a holding slot holds a write to register i
//   wr_count                        committed writes since reset, wraps modulo 2^CNT_W
module reg_wb_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    input  logic [4:0]       req0_addr,
    input  logic [31:0]      req0_data,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [4:0]       req1_addr,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,

    output logic             wr_en,
    output logic [4:0]       wr_addr,
    output logic [31:0]      wr_data,
    output logic [31:0]      busy_mask,
    output logic [CNT_W-1:0] wr_count
);

    // ------------------------------------------------------------------
    // Requester inputs gathered into indexable form
    // ------------------------------------------------------------------
    logic [1:0]  req_valid;
    logic [4:0]  req_addr [2];
    logic [31:0] req_data [2];

    assign req_valid   = {req1_valid, req0_valid};
    assign req_addr[0] = req0_addr;
    assign req_addr[1] = req1_addr;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    // ------------------------------------------------------------------
    // Holding slots: one per requester
    // ------------------------------------------------------------------
    logic [1:0]  slot_vld_q, slot_vld_d;
    logic [4:0]  slot_addr_q [2];
    logic [4:0]  slot_addr_d [2];
    logic [31:0] slot_data_q [2];
    logic [31:0] slot_data_d [2];
    // age_q[n] set means slot n was loaded on an earlier edge than the other
    // (currently full) slot; both clear means equal age or at most one full.
    logic [1:0]  age_q, age_d;
    // Round-robin pointer: requester favoured on the next same-age tie.
    logic        rr_q, rr_d;

    logic              wr_en_q, wr_en_d;
    logic [4:0]        wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic [1:0] grant;
    logic       grant_idx;
    logic       tie;

    always_comb begin
        grant = 2'b00;
        tie   = 1'b0;
        case (slot_vld_q)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (age_q[0]) begin
                    grant = 2'b01;
                end else if (age_q[1]) begin
                    grant = 2'b10;
                end else begin
                    tie   = 1'b1;
                    grant = rr_q ? 2'b10 : 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    assign grant_idx = grant[1];

    // ------------------------------------------------------------------
    // Handshake: a granted slot drains at the edge, so it may refill then.
    // ------------------------------------------------------------------
    logic [1:0] ready;
    logic [1:0] load;
    logic [1:0] kept;

    assign ready      = ~slot_vld_q | grant;
    assign load       = req_valid & ready;
    assign kept       = slot_vld_q & ~grant;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    // ------------------------------------------------------------------
    // Slot next state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_addr_d[i] = slot_addr_q[i];
            slot_data_d[i] = slot_data_q[i];
            if (load[i]) begin
                slot_addr_d[i] = req_addr[i];
                slot_data_d[i] = req_data[i];
            end
        end
        slot_vld_d = load | kept;
        // A slot that survives the edge is older than a slot filled at that
        // edge. At most one slot drains per edge, so two survivors never occur
        // with both full, and two fresh loads leave both bits clear (a tie).
        age_d[0] = kept[0] & slot_vld_d[1] & ~kept[1];
        age_d[1] = kept[1] & slot_vld_d[0] & ~kept[0];
        // Pointer moves only when a tie was actually resolved this cycle.
        rr_d = tie ? ~grant_idx : rr_q;
    end

    // ------------------------------------------------------------------
    // Write port and commit counter
    // ------------------------------------------------------------------
    always_comb begin
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (|grant) begin
            // Register 0 is hard-wired: the slot drains but nothing is written.
            wr_en_d   = (slot_addr_q[grant_idx] != 5'd0);
            wr_addr_d = slot_addr_q[grant_idx];
            wr_data_d = slot_data_q[grant_idx];
        end
        wr_count_d = wr_en_d ? (wr_count_q + CNT_W'(1)) : wr_count_q;
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard for hazard detection upstream
    // ------------------------------------------------------------------
    always_comb begin
        busy_mask = 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (slot_vld_q[i]) begin
                busy_mask[slot_addr_q[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld_q <= 2'b00;
            age_q      <= 2'b00;
            rr_q       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i] <= 5'd0;
                slot_data_q[i] <= 32'd0;
            end
        end else begin
            slot_vld_q <= slot_vld_d;
            age_q      <= age_d;
            rr_q       <= rr_d;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 32'd0;
            wr_count_q <= '0;
        end else begin
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
`timescale 1ns/1ps
// Testbench for reg_wb_arbiter: directed scenarios plus randomized traffic.
// A reference model tracks each held write with the edge it was accepted on;
// grants go to the earliest acceptance, ties to a round-robin preference.
module tb_reg_wb_arbiter;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic [4:0]       req0_addr = '0;
    logic [31:0]      req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [4:0]       req1_addr = '0;
    logic [31:0]      req1_data = '0;
    logic             req1_ready;
    logic             wr_en;
    logic [4:0]       wr_addr;
    logic [31:0]      wr_data;
    logic [31:0]      busy_mask;
    logic [CNT_W-1:0] wr_count;

    reg_wb_arbiter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy_mask  (busy_mask),
        .wr_count   (wr_count)
    );

    initial forever #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected write-port contents, tagged with the edge count at which they appear.
    typedef struct {
        int          cyc;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: a held write per requester with its acceptance edge.
    logic        m_vld   [2];
    logic [4:0]  m_addr  [2];
    logic [31:0] m_data  [2];
    int          m_stamp [2];
    int          m_rr = 0;

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_vld[i]   = 1'b0;
            m_addr[i]  = '0;
            m_data[i]  = '0;
            m_stamp[i] = 0;
        end
        m_rr = 0;
    endtask

    // Called at the falling edge: checks combinational outputs for the current
    // cycle, then advances the model across the next rising edge.
    task automatic model_cycle();
        int          g;
        logic        tie;
        logic [1:0]  rdy;
        logic [31:0] busy;
        logic        v [2];
        logic [4:0]  a [2];
        logic [31:0] d [2];
        v[0] = req0_valid; a[0] = req0_addr; d[0] = req0_data;
        v[1] = req1_valid; a[1] = req1_addr; d[1] = req1_data;
        g   = -1;
        tie = 1'b0;
        if (m_vld[0] && m_vld[1]) begin
            if (m_stamp[0] < m_stamp[1])      g = 0;
            else if (m_stamp[1] < m_stamp[0]) g = 1;
            else begin
                g   = m_rr;
                tie = 1'b1;
            end
        end else if (m_vld[0]) begin
            g = 0;
        end else if (m_vld[1]) begin
            g = 1;
        end
        busy = '0;
        for (int i = 0; i < 2; i++) begin
            rdy[i] = !m_vld[i] || (g == i);
            if (m_vld[i] && m_addr[i] != 5'd0) busy[m_addr[i]] = 1'b1;
        end
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, rdy[0]});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, rdy[1]});
        chk("busy_mask", {32'd0, busy_mask}, {32'd0, busy});
        if (g >= 0) begin
            exp_q.push_back('{cyc + 1, (m_addr[g] != 5'd0), m_addr[g], m_data[g]});
            m_vld[g] = 1'b0;
            if (tie) m_rr = 1 - g;
        end
        for (int i = 0; i < 2; i++) begin
            if (v[i] && rdy[i]) begin
                m_vld[i]   = 1'b1;
                m_addr[i]  = a[i];
                m_data[i]  = d[i];
                m_stamp[i] = cyc + 1;
            end
        end
    endtask

    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
        end
    endtask

    // Monitor: compares the registered write port against the expected queue.
    logic [CNT_W-1:0] exp_count = '0;
    logic [4:0]       last_addr = '0;
    logic [31:0]      last_data = '0;

    initial begin
        exp_t it;
        logic exp_we;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
                chk("rst_wr_count", {48'd0, wr_count}, 64'd0);
                exp_count = '0;
                last_addr = '0;
                last_data = '0;
            end else begin
                exp_we = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    it        = exp_q.pop_front();
                    exp_we    = it.we;
                    last_addr = it.addr;
                    last_data = it.data;
                    if (it.we) exp_count = exp_count + 1'b1;
                end
                chk("wr_en", {63'd0, wr_en}, {63'd0, exp_we});
                chk("wr_addr", {59'd0, wr_addr}, {59'd0, last_addr});
                chk("wr_data", {32'd0, wr_data}, {32'd0, last_data});
                chk("wr_count", {48'd0, wr_count}, {48'd0, exp_count});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_req0_ready", {63'd0, req0_ready}, 64'd1);
        chk("rst_req1_ready", {63'd0, req1_ready}, 64'd1);
        chk("rst_busy_mask", {32'd0, busy_mask}, 64'd0);
        #2 rst_n = 1'b1;

        // Same-edge ties: first favours requester 0, the next favours requester 1.
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        idle(3);
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        idle(3);

        // Single uncontended write.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Register 0: drained but never written.
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Both requesters streaming.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 5'(1 + (i % 31)), 32'(i), 1'b1, 5'(1 + ((i + 7) % 31)), ~32'(i));
        end
        idle(3);

        rand_steps(400);
        idle(3);

        // Asynchronous reset with both slots full; requesters keep offering during reset.
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_clear();
        #1;
        chk("midrst_req0_ready", {63'd0, req0_ready}, 64'd1);
        chk("midrst_req1_ready", {63'd0, req1_ready}, 64'd1);
        chk("midrst_busy_mask", {32'd0, busy_mask}, 64'd0);
        chk("midrst_wr_en", {63'd0, wr_en}, 64'd0);
        @(negedge clk);
        #2;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;

        // Same-address ordering: older 0xA from requester 1 commits before 0xB.
        step(1'b1, 5'd9, 32'h1, 1'b1, 5'd7, 32'hA);
        step(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'd0);
        idle(4);

        rand_steps(200);
        idle(5);

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL take parameter: CNT_W, default 16, width of the committed-write counter.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid  input  1  requester 0 (ALU writeback) offers a write.
REQ-006 req0_addr  input  5  requester 0 destination register.
REQ-007 req0_data  input  32  requester 0 write data.
REQ-008 req0_ready  output  1  requester 0 slot can accept this cycle.
REQ-009 req1_valid, req1_addr[4:0], req1_data[31:0], req1_ready SHALL mirror REQ-005..008 for requester 1 (memory/load writeback).
REQ-010 wr_en  output  1  register-file write enable, registered.
REQ-011 wr_addr  output  5  register-file write address, registered.
REQ-012 wr_data  output  32  register-file write data, registered.
REQ-013 busy_mask  output  32  bit i set while any holding slot contains a write to register i.
REQ-014 wr_count  output  CNT_W  number of committed (wr_en=1) writes since reset.

Function
REQ-015 Each requester SHALL own one holding slot (valid, addr, data, age bit).
REQ-016 Transfer SHALL occur on a rising edge where reqN_valid and reqN_ready are both 1; the slot loads addr/data at that edge.
REQ-017 reqN_ready SHALL be combinational: 1 when slot N is empty, or full and granted this cycle (drain and refill on the same edge allowed).
REQ-018 Each cycle with at least one slot full, exactly one slot SHALL be granted and emptied at the next edge.
REQ-019 Grant selection: only one slot full -> that slot; both full -> the older slot (loaded on an earlier edge); both loaded on the same edge -> round-robin pointer.
REQ-020 Round-robin pointer SHALL point to the requester not granted last; it updates only on edges where a same-age tie is resolved.
REQ-021 At the grant edge, wr_addr/wr_data SHALL load the granted slot's contents and wr_en SHALL load 1, except addr 0 loads wr_en=0 (write suppressed, slot still drained).
REQ-022 With no slot full, wr_en SHALL load 0; wr_addr/wr_data SHALL hold their previous values.
REQ-023 Latency: accept at edge k -> wr_en high in the cycle after edge k+1 at the earliest (2-cycle); with contention, +1 cycle per older/winning write.
REQ-024 Same-address writes SHALL commit in acceptance order; the later one is last written.
REQ-025 busy_mask SHALL be combinational from slot state; bit 0 SHALL always read 0.
REQ-026 wr_count SHALL increment by 1 on each edge that loads wr_en=1 and wrap modulo 2^CNT_W.
REQ-027 Sustained throughput SHALL be one write per cycle; with both requesters streaming, grants SHALL alternate (no starvation beyond 1 cycle).

Reset
REQ-028 While rst_n=0: both slots empty, wr_en=0, wr_addr=0, wr_data=0, wr_count=0, round-robin pointer=requester 0, age bits cleared.
REQ-029 During reset req0_ready=req1_ready=1 and busy_mask=0; no transfer SHALL be recorded while rst_n=0.
REQ-030 Reset asserted mid-operation SHALL discard pending slot contents with no write issued; first grant after release SHALL favour requester 0 on a tie.

Verification
REQ-031 Single write: req0 addr=5 data=0xDEADBEEF accepted edge k -> busy_mask[5]=1 for one cycle, wr_en=1/wr_addr=5/wr_data=0xDEADBEEF after edge k+1, wr_count=1.
REQ-032 Tie: req0 (addr 3, 0x11) and req1 (addr 4, 0x22) same edge -> req0 commits first, req1 next cycle; next tie -> req1 first.
REQ-033 Age/order: req1 addr 7=0xA accepted edge k, req0 addr 7=0xB edge k+1 while req1 waits (both full) -> commits 0xA then 0xB; final wr_data for addr 7 is 0xB.
REQ-034 Zero register: req0 addr=0 data=0xFFFFFFFF -> slot drains, wr_en stays 0, busy_mask=0, wr_count unchanged.
REQ-035 Streaming: both valid every cycle for 20 cycles -> 20 commits, alternating requesters, readies each low at most 1 cycle in 2.
REQ-036 Reset mid-flight: both slots full, rst_n pulled low asynchronously -> wr_en=0, busy_mask=0, readies=1 immediately; no write of held data after release.
